// File: rtl/calculator_pkg.sv
// Shared seven-segment definitions: segment lookup, reverse decode and capture FSM states.
// The display driver encodes from the same SEG_LUT, so encode and decode cannot drift.
package calculator_pkg;

    // Lit patterns {g,f,e,d,c,b,a}; entry h is the glyph for hex digit h.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD
    } cap_state_t;

    // Returns {valid, nibble}; nibble is 0 when the pattern is not a hex glyph.
    function automatic logic [4:0] seg_to_hex(input logic [6:0] lit);
        logic [4:0] res;
        res = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (lit == SEG_LUT[i]) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_sync.sv
// Two-flop synchroniser for the asynchronous display pins.
module seg_sync #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [DATA_W-1:0] meta_p0;
    (* ASYNC_REG = "TRUE" *) logic [DATA_W-1:0] sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/seven_segment_capture.sv
// Watches a multiplexed seven-segment display and reconstructs a full frame of
// hex digits, decimal points and blank flags, published atomically.
module seven_segment_capture
    import calculator_pkg::*;
#(
    parameter int NUM_SEGMENTS  = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SEGMENTS-1:0]      anode,
    input  logic [7:0]                   cathode,
    output logic [NUM_SEGMENTS-1:0][3:0] encoded,
    output logic [NUM_SEGMENTS-1:0]      digit_point,
    output logic [NUM_SEGMENTS-1:0]      blank,
    output logic                         frame_done,
    output logic                         decode_err,
    output logic                         anode_err
);

    localparam logic [NUM_SEGMENTS-1:0] ANODE_OFF  = '1;
    localparam logic [7:0]              SETTLE_MAX = 8'(SETTLE_CYCLES);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= SETTLE_MAX) ? SETTLE_MAX : v + 8'd1;
    endfunction

    function automatic logic is_one_cold(input logic [NUM_SEGMENTS-1:0] a);
        return $countones(~a) == 1;
    endfunction

    logic [NUM_SEGMENTS-1:0]      anode_p1, anode_p2;
    logic [7:0]                   cathode_p1, cathode_p2;
    logic [7:0]                   stable_cnt;
    cap_state_t                   state, state_nxt;
    logic                         changed, idle_lvl, settled;
    logic                         do_sample, do_aerr;
    logic [NUM_SEGMENTS-1:0]      sel;
    logic [6:0]                   lit;
    logic [4:0]                   hex;
    logic                         lit_none, lit_bad;
    logic [NUM_SEGMENTS-1:0]      seen;
    logic                         frame_full;
    logic [NUM_SEGMENTS-1:0][3:0] enc_sh;
    logic [NUM_SEGMENTS-1:0]      dp_sh, blank_sh;

    // Stage p1: synchronised pins. Sync flops idle at the all-off level so
    // leaving reset does not look like every digit being lit.
    seg_sync #(
        .DATA_W  (NUM_SEGMENTS),
        .RST_VAL ({NUM_SEGMENTS{1'b1}})
    ) u_sync_anode (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (anode),
        .q     (anode_p1)
    );

    seg_sync #(
        .DATA_W  (8),
        .RST_VAL (8'hFF)
    ) u_sync_cathode (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cathode),
        .q     (cathode_p1)
    );

    // Stage p2: previous value for change detection, plus stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_p2   <= ANODE_OFF;
            cathode_p2 <= 8'hFF;
            stable_cnt <= 8'd0;
        end else begin
            anode_p2   <= anode_p1;
            cathode_p2 <= cathode_p1;
            stable_cnt <= changed ? 8'd0 : sat_inc(stable_cnt);
        end
    end

    assign changed  = (anode_p1 != anode_p2) || (cathode_p1 != cathode_p2);
    assign idle_lvl = (anode_p1 == ANODE_OFF);
    assign settled  = !changed && (stable_cnt == SETTLE_MAX - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_sample = 1'b0;
        do_aerr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!idle_lvl) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (changed) begin
                    state_nxt = idle_lvl ? S_IDLE : S_SETTLE;
                end else if (idle_lvl) begin
                    state_nxt = S_IDLE;
                end else if (settled) begin
                    do_sample = is_one_cold(anode_p1);
                    do_aerr   = !is_one_cold(anode_p1);
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (changed) begin
                    state_nxt = idle_lvl ? S_IDLE : S_SETTLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign sel      = ~anode_p1;
    assign lit      = ~cathode_p1[6:0];
    assign hex      = seg_to_hex(lit);
    assign lit_none = (lit == 7'h00);
    assign lit_bad  = !lit_none && !hex[4];

    // Stage p3: per-digit shadows, collected until every digit has been seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen     <= '0;
            enc_sh   <= '0;
            dp_sh    <= '0;
            blank_sh <= '0;
        end else begin
            seen <= (frame_full ? '0 : seen) | (do_sample ? sel : '0);
            if (do_sample) begin
                for (int i = 0; i < NUM_SEGMENTS; i++) begin
                    if (sel[i]) begin
                        enc_sh[i]   <= hex[3:0];
                        dp_sh[i]    <= ~cathode_p1[7];
                        blank_sh[i] <= lit_none;
                    end
                end
            end
        end
    end

    assign frame_full = &seen;

    // Stage p4: atomic frame publish and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            encoded     <= '0;
            digit_point <= '0;
            blank       <= '0;
            frame_done  <= 1'b0;
            decode_err  <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            frame_done <= frame_full;
            if (frame_full) begin
                encoded     <= enc_sh;
                digit_point <= dp_sh;
                blank       <= blank_sh;
            end
            if (do_sample && lit_bad) begin
                decode_err <= 1'b1;
            end
            if (do_aerr) begin
                anode_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment driver.
- Watches the scanned anode/cathode pins and decodes each lit digit back to a 4-bit hex nibble and a decimal-point flag.
- Presents a complete, atomically-updated frame of NUM_SEGMENTS digits.
- Used for on-board display readback/self-check and as a bench monitor for display paths.

Parameters:
- NUM_SEGMENTS, 8, number of multiplexed digits; equals the anode width.
- SETTLE_CYCLES, 4, cycles that {anode,cathode} must be unchanged before a digit is sampled; legal range 2..255.

Ports:
- clk  input  1  system clock (50 MHz domain).
- rst_n  input  1  asynchronous active-low reset.
- anode  input  NUM_SEGMENTS  digit enables, active-low, one-cold when a digit is lit.
- cathode  input  8  segments, active-low; [6:0] = {g,f,e,d,c,b,a}, [7] = dp.
- encoded  output  NUM_SEGMENTS x 4 (packed [NUM_SEGMENTS-1:0][3:0])  decoded nibble per digit; index i belongs to anode[i].
- digit_point  output  NUM_SEGMENTS  1 = dp lit on digit i.
- blank  output  NUM_SEGMENTS  1 = digit i had all segments off.
- frame_done  output  1  single-cycle pulse when all outputs above update.
- decode_err  output  1  sticky; an unrecognised segment pattern was sampled.
- anode_err  output  1  sticky; more than one anode was low while stable.

Behaviour:
- Reset state: all outputs 0; internal seen mask, shadows and counters 0; FSM in S_IDLE.
- Input path: anode and cathode pass through 2-flop synchronisers; sync'd inputs are also registered once more (prev) for change detection.
- Stable counter: cleared when sync != prev; otherwise increments, saturating at SETTLE_CYCLES.
- FSM states:
  - S_IDLE: anode all-ones, or inputs changing. Go to S_SETTLE when anode != all-ones.
  - S_SETTLE: on any change, stay and restart the count; if anode returns to all-ones, go to S_IDLE. When count reaches SETTLE_CYCLES-1 with no change:
    - anode one-cold: sample, go to S_HOLD.
    - otherwise: set anode_err, go to S_HOLD without sampling.
  - S_HOLD: one sample per stable interval. Any change goes to S_SETTLE, or to S_IDLE if anode is all-ones.
- Sample action for digit i:
  - Decode lit = ~cathode[6:0] using the hex table 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - lit = 00: shadow blank[i]=1, nibble 0.
  - Unmatched pattern: nibble 0, set decode_err.
  - Shadow dp[i] = ~cathode[7]; set seen[i].
  - Re-sampling a digit before the frame completes overwrites its shadow.
- Frame completion:
  - When seen becomes all-ones, the next cycle copies shadows to encoded/digit_point/blank, pulses frame_done for one cycle, and clears seen.
  - Output latency is 1 cycle after the final sample, i.e. sample cycle + 1.
- Simultaneous events: completing sample and new input change in the same cycle; the sample wins and the change is handled next cycle.
- Sticky flags clear only on reset.
- Reset mid-frame discards the partial frame; outputs return to 0.

Decomposition:
- calculator_pkg gains:
  - SEG_LUT, a 16-entry array of 7-bit lit patterns.
  - Function seg_to_hex returning {valid, nibble}.
  - typedef cap_state_t enum {S_IDLE, S_SETTLE, S_HOLD}.
  - The seven-segment driver shares SEG_LUT so encode and decode cannot drift.
- One sub-module: seg_sync, a parameterised 2-flop synchroniser with ASYNC_REG on its flops, async active-low reset.

Test Plan:
- Scan "12345678" (digit i = i+1, dp off), 8 clk per digit, SETTLE_CYCLES=4.
  - Expect one frame_done after the anode[7] sample.
  - Expect encoded = {8,7,6,5,4,3,2,1}, digit_point=00, blank=00, no errors.
- Same scan with a 2-cycle cathode glitch to 0x00 mid-digit-3.
  - Expect no extra sample and no blank; frame still reads digit 3 = 4.
- Digit 5 driven with lit=0x49.
  - Expect decode_err=1, encoded[5]=0, frame_done still fires.
- anode=0xFC held 10 cycles.
  - Expect anode_err=1, seen unchanged, no frame_done.
- Digit 0 blank with dp lit (cathode=0x7F), others "F".
  - Expect blank=01, digit_point=01, encoded[0]=0, others F.
- Assert rst_n low after 4 of 8 digits sampled, then release and rescan "00000000".
  - Expect outputs 0 during reset.
  - Expect exactly one frame_done after a full 8-digit scan.
